// File: rtl/seed_scheduler.sv
// seed_scheduler: round-robin owner of the single TRNG seed accumulator.
// Each grant runs one fresh collection: raise acc_start, wait for the seed,
// present it to exactly one requester with a valid/ack handshake, then zeroize.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req, ack        per-requester level request / seed-consumed strobe
//   seed_out        delivered seed, all-zero whenever seed_valid == 0
//   seed_valid      one-hot presentation strobe for the grantee
//   grant_id        index of the current or last grantee
//   busy            high in every state except idle
//   seeds_served    wrapping count of completed deliveries
//   trng_stall      sticky: collection exceeded TIMEOUT_CYCLES; stall_clr clears
//   acc_start       accumulator start
//   acc_collecting, acc_seed_ready, acc_seed   accumulator status and data
module seed_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned SEED_WIDTH     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         ack,
  output logic [SEED_WIDTH-1:0]      seed_out,
  output logic [NUM_REQ-1:0]         seed_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [15:0]                seeds_served,
  output logic                       trng_stall,
  input  logic                       stall_clr,
  output logic                       acc_start,
  input  logic                       acc_collecting,
  input  logic                       acc_seed_ready,
  input  logic [SEED_WIDTH-1:0]      acc_seed
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StDeliver, StRelease} state_e;

  state_e            state;
  logic [IdW-1:0]    ptr;
  logic [CntW-1:0]   wait_cnt;

  logic [IdW-1:0]     pick;
  logic [IdW-1:0]     ptr_next;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               found;
  int unsigned        idx;
  int unsigned        nxt;

  // First set request at or after the pointer, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[idx[IdW-1:0]]) begin
        pick  = idx[IdW-1:0];
        found = 1'b1;
      end
    end
    nxt          = (32'(pick) + 32'd1) % NUM_REQ;
    ptr_next     = nxt[IdW-1:0];
    grant_onehot = NUM_REQ'(1) << grant_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      ptr          <= '0;
      grant_id     <= '0;
      wait_cnt     <= '0;
      seed_out     <= '0;
      seed_valid   <= '0;
      busy         <= 1'b0;
      seeds_served <= '0;
      trng_stall   <= 1'b0;
      acc_start    <= 1'b0;
    end else begin
      // A set later in this block overrides the clear, so set wins.
      if (stall_clr) trng_stall <= 1'b0;
      unique case (state)
        StIdle: begin
          // A still-asserted seed_ready belongs to a previous grant; never reuse it.
          if (|req && !acc_seed_ready) begin
            grant_id  <= pick;
            ptr       <= ptr_next;
            acc_start <= 1'b1;
            busy      <= 1'b1;
            state     <= StStart;
          end
        end
        StStart: begin
          if (acc_collecting) begin
            wait_cnt <= '0;
            state    <= StWait;
          end
        end
        StWait: begin
          if (wait_cnt != CntW'(TIMEOUT_CYCLES)) wait_cnt <= wait_cnt + CntW'(1);
          // Fires once, on the edge the counter reaches the limit.
          if (wait_cnt == CntW'(TIMEOUT_CYCLES - 1)) trng_stall <= 1'b1;
          if (acc_seed_ready) begin
            acc_start <= 1'b0;
            if (req[grant_id]) begin
              seed_out   <= acc_seed;
              seed_valid <= grant_onehot;
              state      <= StDeliver;
            end else begin
              // Requester withdrew: drop the seed, it is never presented.
              state <= StRelease;
            end
          end
        end
        StDeliver: begin
          if (ack[grant_id] || !req[grant_id]) begin
            seed_out   <= '0;
            seed_valid <= '0;
            if (ack[grant_id]) seeds_served <= seeds_served + 16'd1;
            state <= StRelease;
          end
        end
        StRelease: begin
          if (!acc_seed_ready) begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seed_scheduler.sv
// Self-checking bench for seed_scheduler with a behavioural seed accumulator.
module tb_seed_scheduler;

  localparam int N  = 4;
  localparam int SW = 256;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  ack = '0;
  logic [SW-1:0] seed_out;
  logic [N-1:0]  seed_valid;
  logic [1:0]    grant_id;
  logic          busy;
  logic [15:0]   seeds_served;
  logic          trng_stall;
  logic          stall_clr = 1'b0;
  logic          acc_start;
  logic          acc_collecting;
  logic          acc_seed_ready;
  logic [SW-1:0] acc_seed;

  seed_scheduler #(
    .NUM_REQ       (N),
    .SEED_WIDTH    (SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .ack           (ack),
    .seed_out      (seed_out),
    .seed_valid    (seed_valid),
    .grant_id      (grant_id),
    .busy          (busy),
    .seeds_served  (seeds_served),
    .trng_stall    (trng_stall),
    .stall_clr     (stall_clr),
    .acc_start     (acc_start),
    .acc_collecting(acc_collecting),
    .acc_seed_ready(acc_seed_ready),
    .acc_seed      (acc_seed)
  );

  always #5 clk = ~clk;

  // ---------------- accumulator model ----------------
  int            trng_mode = 1;      // 0: no bytes, 1: every cycle, 2: random gaps
  bit            seq_bytes = 1'b1;   // bytes 1,2,3,... instead of random
  logic [7:0]    byte_ctr;
  int            nbytes;
  logic [SW-1:0] last_seed;
  logic [7:0]    b;
  logic [SW-1:0] s;
  bit            tv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_collecting <= 1'b0;
      acc_seed_ready <= 1'b0;
      acc_seed       <= '0;
      nbytes         <= 0;
      byte_ctr       <= 8'd1;
    end else begin
      tv = (trng_mode == 1) || (trng_mode == 2 && $urandom_range(0, 3) != 0);
      if (acc_start && !acc_collecting && !acc_seed_ready) begin
        acc_collecting <= 1'b1;
        nbytes         <= 0;
      end else if (acc_collecting && tv) begin
        b = seq_bytes ? byte_ctr : 8'($urandom);
        byte_ctr <= byte_ctr + 8'd1;
        s = {acc_seed[SW-9:0], b};
        acc_seed <= s;
        if (nbytes == SW / 8 - 1) begin
          acc_collecting <= 1'b0;
          acc_seed_ready <= 1'b1;
          last_seed      <= s;
        end
        nbytes <= nbytes + 1;
      end
      if (!acc_start && acc_seed_ready) acc_seed_ready <= 1'b0;
    end
  end

  // ---------------- continuous monitors ----------------
  int multi_hot = 0, leak = 0, bad_valid = 0, n_starts = 0;
  bit forbid_valid = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(seed_valid) > 1) multi_hot++;
      if (seed_valid == '0 && seed_out != '0) leak++;
      if (forbid_valid && seed_valid != '0) bad_valid++;
    end
  end

  always @(posedge acc_start) n_starts++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int          n_pass = 0, n_total = 0, n_fail = 0;
  int          ptr_m = 0;
  int          n_grants_exp = 0;
  logic [15:0] exp_served = '0;

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester at or after the pointer.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int arbitrate(input logic [N-1:0] r);
    int g;
    g = rr_pick(r, ptr_m);
    ptr_m = (g + 1) % N;
    n_grants_exp++;
    return g;
  endfunction

  task automatic wait_valid();
    for (int i = 0; i < 600 && seed_valid == '0; i++) @(negedge clk);
  endtask

  task automatic serve(input int gid, input bit clear);
    logic [N-1:0] oh;
    oh = N'(1) << gid;
    wait_valid();
    check("valid_onehot", SW'(seed_valid), SW'(oh));
    check("grant_id", SW'(grant_id), SW'(gid));
    check("seed_out", seed_out, last_seed);
    ack = ~oh;
    @(negedge clk);
    ack = '0;
    check("nongrantee_ack_ignored", SW'(seed_valid), SW'(oh));
    ack = oh;
    @(negedge clk);
    ack = '0;
    exp_served = exp_served + 16'd1;
    check("valid_cleared", SW'(seed_valid), '0);
    check("seed_zeroized", seed_out, '0);
    check("seeds_served", SW'(seeds_served), SW'(exp_served));
    if (clear) req[gid] = 1'b0;
  endtask

  logic [SW-1:0] exp_first;
  logic [SW-1:0] prev_seed;
  logic [N-1:0]  pat;
  int            g;

  initial begin
    exp_first = '0;
    for (int i = 1; i <= SW / 8; i++) exp_first = {exp_first[SW-9:0], 8'(i)};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_seed_out", seed_out, '0);
    check("rst_seed_valid", SW'(seed_valid), '0);
    check("rst_grant_id", SW'(grant_id), '0);
    check("rst_busy", SW'(busy), '0);
    check("rst_served", SW'(seeds_served), '0);
    check("rst_stall", SW'(trng_stall), '0);
    check("rst_acc_start", SW'(acc_start), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request with bytes 0x01..0x20
    req = 4'b0001;
    g = arbitrate(req);
    @(negedge clk);
    check("start_acc_start", SW'(acc_start), 1);
    check("start_busy", SW'(busy), 1);
    wait_valid();
    check("single_seed_value", seed_out, exp_first);
    serve(g, 1'b1);
    seq_bytes = 1'b0;

    // Reset while a seed is presented
    req = 4'b0010;
    g = arbitrate(req);
    wait_valid();
    check("pre_reset_valid", SW'(seed_valid), SW'(4'b0010));
    rst_n = 1'b0;
    #1;
    check("async_seed_out", seed_out, '0);
    check("async_seed_valid", SW'(seed_valid), '0);
    check("async_busy", SW'(busy), '0);
    check("async_acc_start", SW'(acc_start), '0);
    check("async_served", SW'(seeds_served), '0);
    exp_served = '0;
    ptr_m = 0;
    req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    g = arbitrate(req);
    serve(g, 1'b1);
    check("ptr_reset_pick", SW'(g), 0);
    g = arbitrate(req);
    serve(g, 1'b1);

    // Round robin with all requests held
    req = 4'b1111;
    prev_seed = '0;
    for (int k = 0; k < 5; k++) begin
      g = arbitrate(req);
      check("rr_order", SW'(g), SW'(k % N));
      serve(g, 1'b0);
      check("rr_distinct_seed", SW'(last_seed != prev_seed), 1);
      prev_seed = last_seed;
    end
    req = '0;

    // Withdrawal mid-WAIT
    req = 4'b0100;
    g = arbitrate(req);
    for (int i = 0; i < 50 && acc_collecting !== 1'b1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    req = 4'b1000;
    forbid_valid = 1'b1;
    for (int i = 0; i < 200 && grant_id !== 2'd3; i++) @(negedge clk);
    check("withdraw_next_grant", SW'(grant_id), 3);
    check("withdraw_served_same", SW'(seeds_served), SW'(exp_served));
    forbid_valid = 1'b0;
    g = arbitrate(req);
    serve(g, 1'b1);

    // Stall detection and clear priority
    stall_clr = 1'b1;
    @(negedge clk);
    stall_clr = 1'b0;
    check("stall_cleared_idle", SW'(trng_stall), 0);
    trng_mode = 0;
    req = 4'b0001;
    g = arbitrate(req);
    for (int i = 0; i < 50 && acc_collecting !== 1'b1; i++) @(negedge clk);
    repeat (16) @(negedge clk);
    check("stall_not_yet", SW'(trng_stall), 0);
    stall_clr = 1'b1;
    @(negedge clk);
    check("stall_set_wins", SW'(trng_stall), 1);
    @(negedge clk);
    stall_clr = 1'b0;
    check("stall_clr", SW'(trng_stall), 0);
    repeat (10) @(negedge clk);
    check("stall_no_reset", SW'(trng_stall), 0);
    trng_mode = 1;
    serve(g, 1'b1);

    // Randomized patterns with bursty TRNG
    trng_mode = 2;
    for (int it = 0; it < 12; it++) begin
      pat = 4'($urandom_range(1, 15));
      req = pat;
      g = arbitrate(pat);
      serve(g, 1'b0);
      req = '0;
    end
    trng_mode = 1;

    // Counter wrap
    force dut.seeds_served = 16'hFFFF;
    @(negedge clk);
    release dut.seeds_served;
    exp_served = 16'hFFFF;
    req = 4'b0010;
    g = arbitrate(req);
    serve(g, 1'b1);
    check("wrap_zero", SW'(seeds_served), 0);

    repeat (5) @(negedge clk);
    check("idle_at_end", SW'(busy), 0);
    check("never_multi_hot", SW'(multi_hot), 0);
    check("seed_zero_when_invalid", SW'(leak), 0);
    check("withdrawn_never_presented", SW'(bad_valid), 0);
    check("one_start_per_grant", SW'(n_starts), SW'(n_grants_exp));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
